// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg
//   ID/EX pipeline register for the RV32I core. It carries operands and
//   control from decode into execute, with a valid bit, stall and flush
//   control, and automatic load-use bubble insertion. It exports the EX-stage
//   rd and mem-read flag to the hazard unit. Two saturating performance
//   counters record stall cycles and inserted bubbles.
//
// Ports
//   clk, rst           rising-edge clock; synchronous active-high reset
//   i_stall            hold every ex_* register (a coincident flush is ignored)
//   i_flush            write a bubble on the next edge
//   i_id_*             decode-stage instruction fields
//   o_ex_*             registered EX-stage fields
//   o_load_use_haz     combinational load-use hazard (drives the IF/ID stall)
//   o_stall_cnt        saturating count of cycles with stall asserted
//   o_bubble_cnt       saturating count of inserted bubbles (flush or load-use)
// ---------------------------------------------------------------------------
module id_ex_pipe_reg #(
  parameter int          XLEN     = 32,
  parameter int          CTRL_W   = 12,
  parameter int          RADDR_W  = 5,
  parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
  parameter int          CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic               i_id_valid,
  input  logic [XLEN-1:0]    i_id_pc4,
  input  logic [XLEN-1:0]    i_id_op1,
  input  logic [XLEN-1:0]    i_id_op2,
  input  logic [RADDR_W-1:0] i_id_rs1,
  input  logic [RADDR_W-1:0] i_id_rs2,
  input  logic [RADDR_W-1:0] i_id_rd,
  input  logic [CTRL_W-1:0]  i_id_ctrl,
  input  logic               i_id_reg_we,
  input  logic               i_id_mem_read,
  output logic               o_ex_valid,
  output logic [XLEN-1:0]    o_ex_pc4,
  output logic [XLEN-1:0]    o_ex_op1,
  output logic [XLEN-1:0]    o_ex_op2,
  output logic [RADDR_W-1:0] o_ex_rd,
  output logic [CTRL_W-1:0]  o_ex_ctrl,
  output logic               o_ex_reg_we,
  output logic               o_ex_mem_read,
  output logic               o_load_use_haz,
  output logic [CNT_W-1:0]   o_stall_cnt,
  output logic [CNT_W-1:0]   o_bubble_cnt
);

  logic               r_ex_valid;
  logic [XLEN-1:0]    r_ex_pc4;
  logic [XLEN-1:0]    r_ex_op1;
  logic [XLEN-1:0]    r_ex_op2;
  logic [RADDR_W-1:0] r_ex_rd;
  logic [CTRL_W-1:0]  r_ex_ctrl;
  logic               r_ex_reg_we;
  logic               r_ex_mem_read;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic [CNT_W-1:0]   r_bubble_cnt;

  logic               w_rd_match;
  logic               w_load_use_haz;
  logic               w_bubble;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] res;
    if (v == {CNT_W{1'b1}}) begin
      res = v;
    end else begin
      res = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

  // A valid load in EX writing a nonzero rd that the decode instruction reads.
  assign w_rd_match     = (r_ex_rd == i_id_rs1) || (r_ex_rd == i_id_rs2);
  assign w_load_use_haz = r_ex_valid && r_ex_mem_read &&
                          (r_ex_rd != {RADDR_W{1'b0}}) &&
                          i_id_valid && w_rd_match;

  // Stall outranks both bubble sources, so a bubble is only counted when EX
  // actually takes it.
  assign w_bubble = !i_stall && (i_flush || w_load_use_haz);

  // Pipeline register: rst > stall > flush/load-use bubble > normal load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid    <= 1'b0;
      r_ex_pc4      <= {XLEN{1'b0}};
      r_ex_op1      <= {XLEN{1'b0}};
      r_ex_op2      <= {XLEN{1'b0}};
      r_ex_rd       <= {RADDR_W{1'b0}};
      r_ex_ctrl     <= NOP_CTRL;
      r_ex_reg_we   <= 1'b0;
      r_ex_mem_read <= 1'b0;
    end else if (i_stall) begin
      r_ex_valid    <= r_ex_valid;
      r_ex_pc4      <= r_ex_pc4;
      r_ex_op1      <= r_ex_op1;
      r_ex_op2      <= r_ex_op2;
      r_ex_rd       <= r_ex_rd;
      r_ex_ctrl     <= r_ex_ctrl;
      r_ex_reg_we   <= r_ex_reg_we;
      r_ex_mem_read <= r_ex_mem_read;
    end else if (w_bubble) begin
      // Datapath fields keep their old values; only control is killed.
      r_ex_valid    <= 1'b0;
      r_ex_pc4      <= r_ex_pc4;
      r_ex_op1      <= r_ex_op1;
      r_ex_op2      <= r_ex_op2;
      r_ex_rd       <= {RADDR_W{1'b0}};
      r_ex_ctrl     <= NOP_CTRL;
      r_ex_reg_we   <= 1'b0;
      r_ex_mem_read <= 1'b0;
    end else begin
      r_ex_valid    <= i_id_valid;
      r_ex_pc4      <= i_id_pc4;
      r_ex_op1      <= i_id_op1;
      r_ex_op2      <= i_id_op2;
      r_ex_rd       <= i_id_rd;
      r_ex_ctrl     <= i_id_ctrl;
      r_ex_reg_we   <= i_id_reg_we && i_id_valid;
      r_ex_mem_read <= i_id_mem_read && i_id_valid;
    end
  end

  // Stall-cycle performance counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= {CNT_W{1'b0}};
    end else if (i_stall) begin
      r_stall_cnt <= sat_inc(r_stall_cnt);
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  // Inserted-bubble performance counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= {CNT_W{1'b0}};
    end else if (w_bubble) begin
      r_bubble_cnt <= sat_inc(r_bubble_cnt);
    end else begin
      r_bubble_cnt <= r_bubble_cnt;
    end
  end

  assign o_ex_valid     = r_ex_valid;
  assign o_ex_pc4       = r_ex_pc4;
  assign o_ex_op1       = r_ex_op1;
  assign o_ex_op2       = r_ex_op2;
  assign o_ex_rd        = r_ex_rd;
  assign o_ex_ctrl      = r_ex_ctrl;
  assign o_ex_reg_we    = r_ex_reg_we;
  assign o_ex_mem_read  = r_ex_mem_read;
  assign o_load_use_haz = w_load_use_haz;
  assign o_stall_cnt    = r_stall_cnt;
  assign o_bubble_cnt   = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_pipe_reg
//   Scoreboard bench for id_ex_pipe_reg. The driver applies one directed
//   vector per cycle on the falling edge and queues the hand-computed state
//   expected just after the next rising edge. The monitor pops one entry per
//   rising edge and compares every output. A second instance with 2-bit
//   counters shares the inputs to show counter saturation.
// ---------------------------------------------------------------------------
module tb_id_ex_pipe_reg;

  localparam logic [11:0] NOP = 12'h0F0;

  typedef struct packed {
    logic        rst;
    logic        stall;
    logic        flush;
    logic        valid;
    logic [31:0] pc4;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [11:0] ctrl;
    logic        we;
    logic        mr;
  } stim_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc4;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic [11:0] ctrl;
    logic        we;
    logic        mr;
    logic        haz;
    logic [15:0] s;
    logic [15:0] b;
    logic [1:0]  s2;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_pc4;
  logic [31:0] id_op1;
  logic [31:0] id_op2;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [11:0] id_ctrl;
  logic        id_reg_we;
  logic        id_mem_read;

  logic        ex_valid;
  logic [31:0] ex_pc4;
  logic [31:0] ex_op1;
  logic [31:0] ex_op2;
  logic [4:0]  ex_rd;
  logic [11:0] ex_ctrl;
  logic        ex_reg_we;
  logic        ex_mem_read;
  logic        haz;
  logic [15:0] stall_cnt;
  logic [15:0] bubble_cnt;

  logic        ex_valid2;
  logic [31:0] ex_pc4_2;
  logic [31:0] ex_op1_2;
  logic [31:0] ex_op2_2;
  logic [4:0]  ex_rd2;
  logic [11:0] ex_ctrl2;
  logic        ex_reg_we2;
  logic        ex_mem_read2;
  logic        haz2;
  logic [1:0]  stall_cnt2;
  logic [1:0]  bubble_cnt2;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_cycle  = 0;
  exp_t exp_q[$];

  id_ex_pipe_reg #(.NOP_CTRL(NOP), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .i_stall(stall), .i_flush(flush),
    .i_id_valid(id_valid), .i_id_pc4(id_pc4), .i_id_op1(id_op1),
    .i_id_op2(id_op2), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_rd(id_rd), .i_id_ctrl(id_ctrl), .i_id_reg_we(id_reg_we),
    .i_id_mem_read(id_mem_read),
    .o_ex_valid(ex_valid), .o_ex_pc4(ex_pc4), .o_ex_op1(ex_op1),
    .o_ex_op2(ex_op2), .o_ex_rd(ex_rd), .o_ex_ctrl(ex_ctrl),
    .o_ex_reg_we(ex_reg_we), .o_ex_mem_read(ex_mem_read),
    .o_load_use_haz(haz), .o_stall_cnt(stall_cnt), .o_bubble_cnt(bubble_cnt)
  );

  id_ex_pipe_reg #(.NOP_CTRL(NOP), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .i_stall(stall), .i_flush(flush),
    .i_id_valid(id_valid), .i_id_pc4(id_pc4), .i_id_op1(id_op1),
    .i_id_op2(id_op2), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_rd(id_rd), .i_id_ctrl(id_ctrl), .i_id_reg_we(id_reg_we),
    .i_id_mem_read(id_mem_read),
    .o_ex_valid(ex_valid2), .o_ex_pc4(ex_pc4_2), .o_ex_op1(ex_op1_2),
    .o_ex_op2(ex_op2_2), .o_ex_rd(ex_rd2), .o_ex_ctrl(ex_ctrl2),
    .o_ex_reg_we(ex_reg_we2), .o_ex_mem_read(ex_mem_read2),
    .o_load_use_haz(haz2), .o_stall_cnt(stall_cnt2), .o_bubble_cnt(bubble_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t S(input logic r, input logic st, input logic fl,
                              input logic v, input logic [31:0] pc4,
                              input logic [31:0] op1, input logic [31:0] op2,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [11:0] ctrl,
                              input logic we, input logic mr);
    stim_t x;
    x = '{r, st, fl, v, pc4, op1, op2, rs1, rs2, rd, ctrl, we, mr};
    return x;
  endfunction

  function automatic exp_t E(input logic v, input logic [31:0] pc4,
                             input logic [31:0] op1, input logic [31:0] op2,
                             input logic [4:0] rd, input logic [11:0] ctrl,
                             input logic we, input logic mr, input logic hz,
                             input logic [15:0] s, input logic [15:0] b,
                             input logic [1:0] s2);
    exp_t x;
    x = '{v, pc4, op1, op2, rd, ctrl, we, mr, hz, s, b, s2};
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, n_cycle, got, want);
    end
  endtask

  // Apply one vector on the falling edge and queue its post-edge expectation.
  task automatic step(input stim_t s, input exp_t e);
    @(negedge clk);
    rst         = s.rst;
    stall       = s.stall;
    flush       = s.flush;
    id_valid    = s.valid;
    id_pc4      = s.pc4;
    id_op1      = s.op1;
    id_op2      = s.op2;
    id_rs1      = s.rs1;
    id_rs2      = s.rs2;
    id_rd       = s.rd;
    id_ctrl     = s.ctrl;
    id_reg_we   = s.we;
    id_mem_read = s.mr;
    exp_q.push_back(e);
  endtask

  // Monitor: one expected entry is consumed per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cycle++;
        chk("ex_valid",    {31'd0, ex_valid},    {31'd0, e.valid});
        chk("ex_pc4",      ex_pc4,               e.pc4);
        chk("ex_op1",      ex_op1,               e.op1);
        chk("ex_op2",      ex_op2,               e.op2);
        chk("ex_rd",       {27'd0, ex_rd},       {27'd0, e.rd});
        chk("ex_ctrl",     {20'd0, ex_ctrl},     {20'd0, e.ctrl});
        chk("ex_reg_we",   {31'd0, ex_reg_we},   {31'd0, e.we});
        chk("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, e.mr});
        chk("load_use",    {31'd0, haz},         {31'd0, e.haz});
        chk("stall_cnt",   {16'd0, stall_cnt},   {16'd0, e.s});
        chk("bubble_cnt",  {16'd0, bubble_cnt},  {16'd0, e.b});
        chk("sat_stall",   {30'd0, stall_cnt2},  {30'd0, e.s2});
        chk("sat_bubble",  {30'd0, bubble_cnt2}, {30'd0, e.b[1:0]});
      end
    end
  end

  initial begin
    stim_t g;
    exp_t  rz;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
    id_pc4 = 32'd0; id_op1 = 32'd0; id_op2 = 32'd0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0; id_ctrl = 12'd0;
    id_reg_we = 1'b0; id_mem_read = 1'b0;

    rz = E(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, NOP, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 2'd0);

    // Reset with garbage on the inputs, plus stall/flush that must be ignored.
    g = S(1'b1, 1'b1, 1'b0, 1'b1, 32'h1111, 32'h2222, 32'h3333, 5'd5, 5'd5, 5'd7, 12'hABC, 1'b1, 1'b1);
    step(g, rz);
    g.stall = 1'b0; g.flush = 1'b1;
    step(g, rz);

    // Normal load, one-cycle latency.
    step(S(1'b0, 1'b0, 1'b0, 1'b1, 32'h104, 32'hDEADBEEF, 32'h11, 5'd1, 5'd2, 5'd3, 12'h123, 1'b1, 1'b0),
         E(1'b1, 32'h104, 32'hDEADBEEF, 32'h11, 5'd3, 12'h123, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 2'd0));

    // Six stall cycles (flush held on three of them): EX frozen, counters climb.
    step(S(1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 32'h1, 32'h2, 5'd3, 5'd3, 5'd9, 12'h555, 1'b0, 1'b1),
         E(1'b1, 32'h104, 32'hDEADBEEF, 32'h11, 5'd3, 12'h123, 1'b1, 1'b0, 1'b0, 16'd1, 16'd0, 2'd1));
    step(S(1'b0, 1'b1, 1'b0, 1'b0, 32'h204, 32'h3, 32'h4, 5'd5, 5'd6, 5'd10, 12'h666, 1'b1, 1'b1),
         E(1'b1, 32'h104, 32'hDEADBEEF, 32'h11, 5'd3, 12'h123, 1'b1, 1'b0, 1'b0, 16'd2, 16'd0, 2'd2));
    step(S(1'b0, 1'b1, 1'b1, 1'b1, 32'h208, 32'h5, 32'h6, 5'd7, 5'd8, 5'd11, 12'h777, 1'b1, 1'b0),
         E(1'b1, 32'h104, 32'hDEADBEEF, 32'h11, 5'd3, 12'h123, 1'b1, 1'b0, 1'b0, 16'd3, 16'd0, 2'd3));
    step(S(1'b0, 1'b1, 1'b1, 1'b1, 32'h20C, 32'h7, 32'h8, 5'd3, 5'd3, 5'd12, 12'h888, 1'b0, 1'b0),
         E(1'b1, 32'h104, 32'hDEADBEEF, 32'h11, 5'd3, 12'h123, 1'b1, 1'b0, 1'b0, 16'd4, 16'd0, 2'd3));
    step(S(1'b0, 1'b1, 1'b1, 1'b0, 32'h210, 32'h9, 32'hA, 5'd1, 5'd1, 5'd13, 12'h999, 1'b1, 1'b1),
         E(1'b1, 32'h104, 32'hDEADBEEF, 32'h11, 5'd3, 12'h123, 1'b1, 1'b0, 1'b0, 16'd5, 16'd0, 2'd3));
    step(S(1'b0, 1'b1, 1'b0, 1'b1, 32'h214, 32'hB, 32'hC, 5'd2, 5'd2, 5'd14, 12'hAAA, 1'b1, 1'b1),
         E(1'b1, 32'h104, 32'hDEADBEEF, 32'h11, 5'd3, 12'h123, 1'b1, 1'b0, 1'b0, 16'd6, 16'd0, 2'd3));

    // Load x5 (rs1=x5): with ID still showing rs1=5 the hazard is raised.
    step(S(1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 32'hAAAA, 32'hBBBB, 5'd5, 5'd2, 5'd5, 12'h0AB, 1'b1, 1'b1),
         E(1'b1, 32'h300, 32'hAAAA, 32'hBBBB, 5'd5, 12'h0AB, 1'b1, 1'b1, 1'b1, 16'd6, 16'd0, 2'd3));
    // Consumer reads rs2=5: bubble, pc4/op1/op2 kept.
    step(S(1'b0, 1'b0, 1'b0, 1'b1, 32'h304, 32'hCCCC, 32'hDDDD, 5'd6, 5'd5, 5'd7, 12'h0CD, 1'b1, 1'b0),
         E(1'b0, 32'h300, 32'hAAAA, 32'hBBBB, 5'd0, NOP, 1'b0, 1'b0, 1'b0, 16'd6, 16'd1, 2'd3));
    // Consumer re-enters.
    step(S(1'b0, 1'b0, 1'b0, 1'b1, 32'h304, 32'hCCCC, 32'hDDDD, 5'd6, 5'd5, 5'd7, 12'h0CD, 1'b1, 1'b0),
         E(1'b1, 32'h304, 32'hCCCC, 32'hDDDD, 5'd7, 12'h0CD, 1'b1, 1'b0, 1'b0, 16'd6, 16'd1, 2'd3));

    // Load to x0 never creates a hazard.
    step(S(1'b0, 1'b0, 1'b0, 1'b1, 32'h400, 32'h1234, 32'h5678, 5'd0, 5'd0, 5'd0, 12'h0EE, 1'b1, 1'b1),
         E(1'b1, 32'h400, 32'h1234, 32'h5678, 5'd0, 12'h0EE, 1'b1, 1'b1, 1'b0, 16'd6, 16'd1, 2'd3));
    step(S(1'b0, 1'b0, 1'b0, 1'b1, 32'h404, 32'h4321, 32'h8765, 5'd0, 5'd0, 5'd8, 12'h011, 1'b1, 1'b0),
         E(1'b1, 32'h404, 32'h4321, 32'h8765, 5'd8, 12'h011, 1'b1, 1'b0, 1'b0, 16'd6, 16'd1, 2'd3));

    // Invalid instruction: write enable and load flag gated off.
    step(S(1'b0, 1'b0, 1'b0, 1'b0, 32'h500, 32'h5555, 32'h6666, 5'd8, 5'd8, 5'd9, 12'h077, 1'b1, 1'b1),
         E(1'b0, 32'h500, 32'h5555, 32'h6666, 5'd9, 12'h077, 1'b0, 1'b0, 1'b0, 16'd6, 16'd1, 2'd3));

    // Flush with a valid instruction: bubble, op1 retains old value.
    step(S(1'b0, 1'b0, 1'b0, 1'b1, 32'h600, 32'h7777, 32'h8888, 5'd1, 5'd2, 5'd8, 12'h099, 1'b1, 1'b1),
         E(1'b1, 32'h600, 32'h7777, 32'h8888, 5'd8, 12'h099, 1'b1, 1'b1, 1'b0, 16'd6, 16'd1, 2'd3));
    step(S(1'b0, 1'b0, 1'b1, 1'b1, 32'h700, 32'h9999, 32'hAAAA, 5'd8, 5'd8, 5'd3, 12'h033, 1'b1, 1'b0),
         E(1'b0, 32'h600, 32'h7777, 32'h8888, 5'd0, NOP, 1'b0, 1'b0, 1'b0, 16'd6, 16'd2, 2'd3));

    // Matching rs but id_valid=0: no hazard, plain load of an invalid slot.
    step(S(1'b0, 1'b0, 1'b0, 1'b1, 32'h800, 32'h1, 32'h2, 5'd4, 5'd0, 5'd4, 12'h044, 1'b1, 1'b1),
         E(1'b1, 32'h800, 32'h1, 32'h2, 5'd4, 12'h044, 1'b1, 1'b1, 1'b1, 16'd6, 16'd2, 2'd3));
    step(S(1'b0, 1'b0, 1'b0, 1'b0, 32'h804, 32'h3, 32'h4, 5'd4, 5'd4, 5'd6, 12'h066, 1'b1, 1'b0),
         E(1'b0, 32'h804, 32'h3, 32'h4, 5'd6, 12'h066, 1'b0, 1'b0, 1'b0, 16'd6, 16'd2, 2'd3));

    // Reset while a hazard is pending and stall is high clears everything.
    step(S(1'b0, 1'b0, 1'b0, 1'b1, 32'h900, 32'h5, 32'h6, 5'd4, 5'd0, 5'd4, 12'h044, 1'b1, 1'b1),
         E(1'b1, 32'h900, 32'h5, 32'h6, 5'd4, 12'h044, 1'b1, 1'b1, 1'b1, 16'd6, 16'd2, 2'd3));
    step(S(1'b1, 1'b1, 1'b0, 1'b1, 32'h900, 32'h5, 32'h6, 5'd4, 5'd0, 5'd4, 12'h044, 1'b1, 1'b1), rz);
    step(S(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 12'h000, 1'b0, 1'b0),
         E(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 12'h000, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 2'd0));
    step(S(1'b0, 1'b0, 1'b1, 1'b1, 32'hA00, 32'h1, 32'h1, 5'd0, 5'd0, 5'd1, 12'h001, 1'b1, 1'b1),
         E(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, NOP, 1'b0, 1'b0, 1'b0, 16'd0, 16'd1, 2'd0));

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
